mult4u_residue_check: RTL and testbench
=======================================

MULT4U_RESIDUE_CHECK -- requirements
Module: mult4u_residue_check

Interface
REQ-001 Parameter CNT_W, default 8: width of the saturating error counter.
REQ-002 Parameter FAULT_THRESH, default 2: consecutive erroneous results that force state FAULT; legal range 1..15.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port in_valid  input  1  upstream operand/product triple is valid.
REQ-006 Port in_ready  output  1  block accepts the triple this cycle.
REQ-007 Port a  input  4  unsigned multiplicand, A[3:0].
REQ-008 Port b  input  4  unsigned multiplier, B[3:0].
REQ-009 Port p  input  8  product from the upstream 4x4 unsigned multiplier, O[7:0].
REQ-010 Port out_valid  output  1  checked result is valid.
REQ-011 Port out_ready  input  1  downstream accepts the result.
REQ-012 Port out_p  output  8  product forwarded unchanged.
REQ-013 Port out_err  output  1  residue mismatch detected for out_p.
REQ-014 Port err_count  output  CNT_W  saturating count of erroneous results delivered.
REQ-015 Port fault  output  1  high while state = FAULT.
REQ-016 Port clear  input  1  clears err_count and returns state to OK.

Function
REQ-017 Stage 1 SHALL register a mod 3, b mod 3 and p mod 3, plus p, on an accepted input (in_valid && in_ready).
REQ-018 Stage 2 SHALL register out_err = ((ra*rb) mod 3 != rp), plus p.
REQ-019 Latency SHALL be exactly 2 cycles from input handshake to out_valid under no backpressure; throughput is 1 triple per cycle.
REQ-020 Stage 2 SHALL advance when !s2_valid || out_ready; stage 1 SHALL advance when !s1_valid || stage 2 advances; in_ready = !s1_valid || stage-2 advance (combinational).
REQ-021 While out_valid && !out_ready, out_p, out_err and out_valid SHALL hold stable; no triple is dropped or duplicated.
REQ-022 err_count, the health state machine and fault SHALL update only on an output handshake (out_valid && out_ready).
REQ-023 err_count SHALL increment by 1 per handshake with out_err = 1 and saturate at 2^CNT_W-1.
REQ-024 Health FSM states: OK, SUSPECT, FAULT; internal run counter tracks consecutive errors.
REQ-025 OK -> SUSPECT on an erroneous handshake when FAULT_THRESH > 1; OK -> FAULT directly when FAULT_THRESH = 1.
REQ-026 SUSPECT -> FAULT when the run counter reaches FAULT_THRESH; SUSPECT -> OK on a clean handshake (run counter cleared).
REQ-027 FAULT is sticky: leaves only via clear or rst, to OK.
REQ-028 clear coinciding with an erroneous handshake: clear wins; err_count = 0, state OK, run counter 0.
REQ-029 The datapath SHALL be unaffected by clear and fault; results keep flowing in state FAULT.

Reset
REQ-030 rst SHALL clear s1_valid, s2_valid, out_valid, out_err, out_p, err_count, run counter and fault, and set state OK; in_ready is 1 in the first cycle after reset.
REQ-031 rst mid-operation SHALL discard in-flight triples with no output handshake and no counter change.

Configuration
REQ-032 Macro MULT4U_RESCHK_MOD7_EN: when defined, stage 1 additionally registers residues mod 7 and out_err = mod-3 mismatch OR mod-7 mismatch.
REQ-033 Without MULT4U_RESCHK_MOD7_EN: mod-3 check only, no mod-7 logic; all other behaviour identical.

Structure
REQ-034 Package mult4u_pkg SHALL hold the health-state enum typedef, residue-width constants and the moduli 3 and 7.
REQ-035 Sub-module mult4u_residue (combinational, parametric input width and modulus) SHALL compute each residue; instantiated per operand/modulus.

Verification
REQ-036 a=7, b=9, p=63, out_ready=1 -> out_valid 2 cycles later, out_p=63, out_err=0, err_count=0, state OK.
REQ-037 a=7, b=9, p=62 twice back-to-back, FAULT_THRESH=2 -> out_err=1 both times, err_count=2, fault=1 after the second handshake.
REQ-038 a=7, b=9, p=60 -> out_err=0 without the macro; out_err=1 with MULT4U_RESCHK_MOD7_EN.
REQ-039 Three triples in, out_ready held low 5 cycles -> in_ready drops after the second triple, outputs stable, all three delivered in order once out_ready=1.
REQ-040 CNT_W=2, five erroneous results -> err_count saturates at 3; clear -> err_count=0, fault=0.
REQ-041 rst asserted with two triples in flight -> no out_valid afterwards, err_count=0, state OK.

Source files
------------

// File: rtl/mult4u_pkg.sv
// rtl/mult4u_pkg.sv - shared types and constants for the 4x4 multiplier residue checker
package mult4u_pkg;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_FAULT   = 2'd2
    } health_t;

    localparam int MOD3   = 3;
    localparam int MOD7   = 7;
    localparam int RES3_W = 2;
    localparam int RES7_W = 3;
    localparam int RUN_W  = 4;

endpackage

// File: rtl/mult4u_residue.sv
// rtl/mult4u_residue.sv - combinational residue of an unsigned value modulo a constant
module mult4u_residue #(
    parameter int IN_W  = 4,
    parameter int MOD   = 3,
    parameter int OUT_W = 2
) (
    input  logic [IN_W-1:0]  i_val,
    output logic [OUT_W-1:0] o_res
);

    localparam logic [IN_W-1:0] MOD_V = IN_W'(MOD);

    assign o_res = OUT_W'(i_val % MOD_V);

endmodule

// File: rtl/mult4u_residue_check.sv
// rtl/mult4u_residue_check.sv - two-stage residue checker with health FSM; MULT4U_RESCHK_MOD7_EN adds a mod-7 check
module mult4u_residue_check
    import mult4u_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int FAULT_THRESH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    input  logic [7:0]       p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_p,
    output logic             out_err,
    output logic [CNT_W-1:0] err_count,
    output logic             fault,
    input  logic             clear
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [RUN_W-1:0] THRESH  = RUN_W'(FAULT_THRESH);

    logic              w_s1_adv;
    logic              w_s2_adv;
    logic              w_hs;
    logic [RES3_W-1:0] w_ra3;
    logic [RES3_W-1:0] w_rb3;
    logic [RES3_W-1:0] w_rp3;
    logic [3:0]        w_prod3;
    logic [RES3_W-1:0] w_prod3_res;
    logic              w_err;

    logic              r_s1_valid;
    logic [7:0]        r_s1_p;
    logic [RES3_W-1:0] r_s1_ra3;
    logic [RES3_W-1:0] r_s1_rb3;
    logic [RES3_W-1:0] r_s1_rp3;
    logic              r_s2_valid;
    logic [7:0]        r_s2_p;
    logic              r_s2_err;

    health_t           r_state;
    health_t           w_state_next;
    logic [RUN_W-1:0]  r_run;
    logic [RUN_W-1:0]  w_run_next;
    logic [CNT_W-1:0]  r_err_count;
    logic              w_fault;

    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;
    assign w_hs     = r_s2_valid && out_ready;

    mult4u_residue #(.IN_W(4), .MOD(MOD3), .OUT_W(RES3_W)) u_res_a3 (.i_val(a), .o_res(w_ra3));
    mult4u_residue #(.IN_W(4), .MOD(MOD3), .OUT_W(RES3_W)) u_res_b3 (.i_val(b), .o_res(w_rb3));
    mult4u_residue #(.IN_W(8), .MOD(MOD3), .OUT_W(RES3_W)) u_res_p3 (.i_val(p), .o_res(w_rp3));

    assign w_prod3 = {2'b00, r_s1_ra3} * {2'b00, r_s1_rb3};
    mult4u_residue #(.IN_W(4), .MOD(MOD3), .OUT_W(RES3_W)) u_res_m3 (.i_val(w_prod3), .o_res(w_prod3_res));

`ifdef MULT4U_RESCHK_MOD7_EN
    logic [RES7_W-1:0] w_ra7;
    logic [RES7_W-1:0] w_rb7;
    logic [RES7_W-1:0] w_rp7;
    logic [5:0]        w_prod7;
    logic [RES7_W-1:0] w_prod7_res;
    logic [RES7_W-1:0] r_s1_ra7;
    logic [RES7_W-1:0] r_s1_rb7;
    logic [RES7_W-1:0] r_s1_rp7;

    mult4u_residue #(.IN_W(4), .MOD(MOD7), .OUT_W(RES7_W)) u_res_a7 (.i_val(a), .o_res(w_ra7));
    mult4u_residue #(.IN_W(4), .MOD(MOD7), .OUT_W(RES7_W)) u_res_b7 (.i_val(b), .o_res(w_rb7));
    mult4u_residue #(.IN_W(8), .MOD(MOD7), .OUT_W(RES7_W)) u_res_p7 (.i_val(p), .o_res(w_rp7));

    assign w_prod7 = {3'b000, r_s1_ra7} * {3'b000, r_s1_rb7};
    mult4u_residue #(.IN_W(6), .MOD(MOD7), .OUT_W(RES7_W)) u_res_m7 (.i_val(w_prod7), .o_res(w_prod7_res));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_ra7 <= '0;
            r_s1_rb7 <= '0;
            r_s1_rp7 <= '0;
        end else if (w_s1_adv && in_valid) begin
            r_s1_ra7 <= w_ra7;
            r_s1_rb7 <= w_rb7;
            r_s1_rp7 <= w_rp7;
        end
    end

    assign w_err = (w_prod3_res != r_s1_rp3) || (w_prod7_res != r_s1_rp7);
`else
    assign w_err = (w_prod3_res != r_s1_rp3);
`endif

    // Datapath pipeline: independent of clear and of the health state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_p     <= '0;
            r_s1_ra3   <= '0;
            r_s1_rb3   <= '0;
            r_s1_rp3   <= '0;
            r_s2_valid <= 1'b0;
            r_s2_p     <= '0;
            r_s2_err   <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_p   <= p;
                    r_s1_ra3 <= w_ra3;
                    r_s1_rb3 <= w_rb3;
                    r_s1_rp3 <= w_rp3;
                end
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_s2_p   <= r_s1_p;
                    r_s2_err <= w_err;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_OK;
            r_run       <= '0;
            r_err_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_run   <= w_run_next;
            if (clear) begin
                r_err_count <= '0;
            end else if (w_hs && r_s2_err && (r_err_count != CNT_MAX)) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    // clear takes priority over any handshake in the same cycle.
    always_comb begin
        w_state_next = r_state;
        w_run_next   = r_run;
        if (clear) begin
            w_state_next = ST_OK;
            w_run_next   = '0;
        end else if (w_hs) begin
            case (r_state)
                ST_OK: begin
                    if (r_s2_err) begin
                        w_run_next   = RUN_W'(1);
                        w_state_next = (THRESH <= RUN_W'(1)) ? ST_FAULT : ST_SUSPECT;
                    end else begin
                        w_run_next = '0;
                    end
                end
                ST_SUSPECT: begin
                    if (r_s2_err) begin
                        w_run_next = r_run + 1'b1;
                        if ((r_run + 1'b1) >= THRESH) begin
                            w_state_next = ST_FAULT;
                        end
                    end else begin
                        w_run_next   = '0;
                        w_state_next = ST_OK;
                    end
                end
                ST_FAULT: begin
                    w_state_next = ST_FAULT;
                end
                default: begin
                    w_state_next = ST_OK;
                    w_run_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_fault = 1'b0;
        if (r_state == ST_FAULT) begin
            w_fault = 1'b1;
        end
    end

    assign out_valid = r_s2_valid;
    assign out_p     = r_s2_p;
    assign out_err   = r_s2_err;
    assign err_count = r_err_count;
    assign fault     = w_fault;

endmodule

// File: tb/tb_mult4u_residue_check.sv
// tb/tb_mult4u_residue_check.sv - directed self-checking bench for mult4u_residue_check
module tb_mult4u_residue_check;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
    logic       out_ready;
    logic       clear;

    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_p;
    logic       out_err;
    logic [1:0] err_count;
    logic       fault;

    logic       t1_in_ready;
    logic       t1_out_valid;
    logic [7:0] t1_out_p;
    logic       t1_out_err;
    logic [7:0] t1_err_count;
    logic       t1_fault;

    int checks   = 0;
    int failures = 0;
    logic exp_mod7_err;

    always #5 clk = ~clk;

    mult4u_residue_check #(.CNT_W(2), .FAULT_THRESH(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .p(p), .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .out_err(out_err), .err_count(err_count),
        .fault(fault), .clear(clear)
    );

    mult4u_residue_check #(.CNT_W(8), .FAULT_THRESH(1)) dut_t1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t1_in_ready),
        .a(a), .b(b), .p(p), .out_valid(t1_out_valid), .out_ready(out_ready),
        .out_p(t1_out_p), .out_err(t1_out_err), .err_count(t1_err_count),
        .fault(t1_fault), .clear(clear)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] ta, input logic [3:0] tb, input logic [7:0] tp);
        in_valid = v;
        a = ta;
        b = tb;
        p = tp;
    endtask

    initial begin
`ifdef MULT4U_RESCHK_MOD7_EN
        exp_mod7_err = 1'b1;
`else
        exp_mod7_err = 1'b0;
`endif
        rst = 1'b1;
        clear = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 4'd0, 4'd0, 8'd0);
        step();
        step();
        rst = 1'b0;
        step();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_p", out_p, 0);
        check("rst_out_err", out_err, 0);
        check("rst_err_count", err_count, 0);
        check("rst_fault", fault, 0);

        // Clean product, latency of two cycles
        drive(1'b1, 4'd7, 4'd9, 8'd63);
        step();
        drive(1'b0, 4'd0, 4'd0, 8'd0);
        check("lat_s1_no_valid", out_valid, 0);
        step();
        check("lat_out_valid", out_valid, 1);
        check("lat_out_p", out_p, 63);
        check("lat_out_err", out_err, 0);
        step();
        check("lat_after_hs_valid", out_valid, 0);
        check("lat_err_count", err_count, 0);
        check("lat_fault", fault, 0);

        // Two back-to-back erroneous products
        drive(1'b1, 4'd7, 4'd9, 8'd62);
        step();
        step();
        drive(1'b0, 4'd0, 4'd0, 8'd0);
        check("err1_out_valid", out_valid, 1);
        check("err1_out_err", out_err, 1);
        step();
        check("err2_out_err", out_err, 1);
        check("err2_count_mid", err_count, 1);
        check("err2_fault_mid", fault, 0);
        check("t1_fault_first_err", t1_fault, 1);
        step();
        check("err2_count", err_count, 2);
        check("err2_fault", fault, 1);
        check("err2_drained", out_valid, 0);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clear_count", err_count, 0);
        check("clear_fault", fault, 0);
        check("clear_t1_fault", t1_fault, 0);

        // 60 is 0 mod 3 but 4 mod 7
        drive(1'b1, 4'd7, 4'd9, 8'd60);
        step();
        drive(1'b0, 4'd0, 4'd0, 8'd0);
        step();
        check("mod7_out_p", out_p, 60);
        check("mod7_out_err", out_err, exp_mod7_err);
        step();
        check("mod7_count", err_count, exp_mod7_err);
        clear = 1'b1;
        step();
        clear = 1'b0;

        // Backpressure: three triples, out_ready low for five cycles
        out_ready = 1'b0;
        drive(1'b1, 4'd2, 4'd3, 8'd6);
        step();
        check("bp_ready_after_t1", in_ready, 1);
        drive(1'b1, 4'd5, 4'd5, 8'd25);
        step();
        check("bp_ready_after_t2", in_ready, 0);
        check("bp_valid", out_valid, 1);
        check("bp_p_t1", out_p, 6);
        drive(1'b1, 4'd15, 4'd15, 8'd225);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_p", out_p, 6);
            check("bp_hold_err", out_err, 0);
            check("bp_hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        drive(1'b0, 4'd0, 4'd0, 8'd0);
        check("bp_t2_valid", out_valid, 1);
        check("bp_t2_p", out_p, 25);
        step();
        check("bp_t3_valid", out_valid, 1);
        check("bp_t3_p", out_p, 225);
        check("bp_t3_err", out_err, 0);
        step();
        check("bp_drained", out_valid, 0);
        check("bp_count", err_count, 0);

        // Five erroneous results saturate a 2-bit counter
        drive(1'b1, 4'd7, 4'd9, 8'd62);
        for (int i = 0; i < 5; i++) step();
        drive(1'b0, 4'd0, 4'd0, 8'd0);
        for (int i = 0; i < 3; i++) step();
        check("sat_count", err_count, 3);
        check("sat_fault", fault, 1);
        check("sat_drained", out_valid, 0);
        check("sat_t1_count", t1_err_count, 5);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("sat_clear_count", err_count, 0);
        check("sat_clear_fault", fault, 0);

        // Reset with two erroneous triples in flight
        drive(1'b1, 4'd7, 4'd9, 8'd62);
        step();
        step();
        drive(1'b0, 4'd0, 4'd0, 8'd0);
        check("rstf_in_flight", out_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstf_in_ready", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            check("rstf_no_valid", out_valid, 0);
            step();
        end
        check("rstf_count", err_count, 0);
        check("rstf_fault", fault, 0);
        check("rstf_t1_fault", t1_fault, 0);

        // A single error after reset proves state OK (SUSPECT, not FAULT)
        drive(1'b1, 4'd7, 4'd9, 8'd62);
        step();
        drive(1'b0, 4'd0, 4'd0, 8'd0);
        step();
        step();
        check("rstf_state_ok_count", err_count, 1);
        check("rstf_state_ok_fault", fault, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
